// File: rtl/seq_hit_counter.sv
// Windowed hit counter: counts z pulses over WINDOW qualified bit-times and
// publishes each window's count through a one-entry valid/ready output register.
module seq_hit_counter #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             z,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun,
    input  logic             clr_overrun
);
    localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [BW-1:0]    LAST = BW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] SAT  = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             ovr_q, ovr_d;
    logic             close;
    logic [CNT_W-1:0] hit_next;

    // hit_next already folds in the current bit, so on close it is the window result
    always_comb begin
        close    = en && (bit_q == LAST);
        hit_next = (en && z && (hit_q != SAT)) ? hit_q + 1'b1 : hit_q;
        bit_d    = bit_q;
        hit_d    = hit_q;
        if (en) begin
            if (close) begin
                bit_d = '0;
                hit_d = '0;
            end else begin
                bit_d = bit_q + 1'b1;
                hit_d = hit_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ovr_d   = ovr_q && !clr_overrun;
        case (state_q)
            EMPTY: begin
                if (close) begin
                    out_d   = hit_next;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (close) begin
                    // A stalled consumer loses the new result; set beats clear
                    if (count_ready) out_d = hit_next;
                    else             ovr_d = 1'b1;
                end else if (count_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            bit_q   <= '0;
            hit_q   <= '0;
            out_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            hit_q   <= hit_d;
            out_q   <= out_d;
            ovr_q   <= ovr_d;
        end
    end

    assign count_out   = out_q;
    assign count_valid = (state_q == FULL);
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench for seq_hit_counter: a CNT_W=4 instance plus a CNT_W=2 instance
// sharing stimulus, the narrow one used for saturation and reset checks.
module tb_seq_hit_counter;
    logic       clk = 1'b0;
    logic       rst, en, z, count_ready, clr_overrun;
    logic [3:0] count_out;
    logic       count_valid, overrun;
    logic [1:0] n_out;
    logic       n_valid, n_ovr;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    seq_hit_counter #(.WINDOW(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .z(z),
        .count_out(count_out), .count_valid(count_valid), .count_ready(count_ready),
        .overrun(overrun), .clr_overrun(clr_overrun));

    seq_hit_counter #(.WINDOW(8), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .en(en), .z(z),
        .count_out(n_out), .count_valid(n_valid), .count_ready(count_ready),
        .overrun(n_ovr), .clr_overrun(clr_overrun));

    task automatic step(input logic e, input logic zz);
        en = e;
        z  = zz;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; z = 1'b0; count_ready = 1'b0; clr_overrun = 1'b0;
        #6;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (count_valid !== 1'b0 || count_out !== 4'd0 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got v=%0b o=%0d ovr=%0b exp v=0 o=0 ovr=0",
                         i, count_valid, count_out, overrun);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'hA4;
        count_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pat[i]);
            checks++;
            if (count_valid !== (i == 7)) begin
                failures++;
                $display("FAIL basic_valid bit=%0d got=%0b exp=%0b", i, count_valid, i == 7);
            end
        end
        checks++;
        if (count_out !== 4'd3) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=3", count_out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (count_valid !== (i == 7)) begin
                failures++;
                $display("FAIL basic_zero_valid bit=%0d got=%0b exp=%0b", i, count_valid, i == 7);
            end
        end
        checks++;
        if (count_out !== 4'd0) begin
            failures++;
            $display("FAIL basic_zero_count got=%0d exp=0", count_out);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_gating();
        logic [7:0] pat;
        pat = 8'hA4;
        count_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pat[i]);
            if (i < 7) begin
                step(1'b0, 1'b1);
                step(1'b0, 1'b1);
                checks++;
                if (count_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gate_early_valid bit=%0d got=%0b exp=0", i, count_valid);
                end
            end
        end
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd3) begin
            failures++;
            $display("FAIL gate_count got v=%0b o=%0d exp v=1 o=3", count_valid, count_out);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        count_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        checks++;
        if (n_valid !== 1'b1 || n_out !== 2'd3) begin
            failures++;
            $display("FAIL sat_narrow got v=%0b o=%0d exp v=1 o=3", n_valid, n_out);
        end
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd8) begin
            failures++;
            $display("FAIL sat_wide got v=%0b o=%0d exp v=1 o=8", count_valid, count_out);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] w1, w2;
        w1 = 8'h03;
        w2 = 8'h1F;
        count_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, w1[i]);
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd2 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_w1 got v=%0b o=%0d ovr=%0b exp v=1 o=2 ovr=0",
                     count_valid, count_out, overrun);
        end
        for (int i = 0; i < 8; i++) step(1'b1, w2[i]);
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd2 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_w2 got v=%0b o=%0d ovr=%0b exp v=1 o=2 ovr=1",
                     count_valid, count_out, overrun);
        end
        count_ready = 1'b1;
        step(1'b0, 1'b0);
        count_ready = 1'b0;
        checks++;
        if (count_valid !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_drain got v=%0b ovr=%0b exp v=0 ovr=1", count_valid, overrun);
        end
        clr_overrun = 1'b1;
        step(1'b0, 1'b0);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear got=%0b exp=0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wa, wb, wc;
        wa = 8'h01;
        wb = 8'h0F;
        wc = 8'h21;
        count_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, wa[i]);
        for (int i = 0; i < 7; i++) step(1'b1, wb[i]);
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd1) begin
            failures++;
            $display("FAIL b2b_hold got v=%0b o=%0d exp v=1 o=1", count_valid, count_out);
        end
        count_ready = 1'b1;
        step(1'b1, wb[7]);
        count_ready = 1'b0;
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd4 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load got v=%0b o=%0d ovr=%0b exp v=1 o=4 ovr=0",
                     count_valid, count_out, overrun);
        end
        // dropped result and clear request on the same edge: overrun must stay set
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        clr_overrun = 1'b1;
        step(1'b1, 1'b0);
        clr_overrun = 1'b0;
        checks++;
        if (count_valid !== 1'b1 || count_out !== 4'd4 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clr got v=%0b o=%0d ovr=%0b exp v=1 o=4 ovr=1",
                     count_valid, count_out, overrun);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        en = 1'b0;
        z  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count_valid !== 1'b0 || count_out !== 4'd0 || overrun !== 1'b0 ||
            n_valid !== 1'b0 || n_out !== 2'd0 || n_ovr !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got v=%0b o=%0d ovr=%0b nv=%0b no=%0d novr=%0b exp all 0",
                     count_valid, count_out, overrun, n_valid, n_out, n_ovr);
        end
        #2;
        rst = 1'b0;
        count_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, wc[i]);
            checks++;
            if (count_valid !== (i == 7)) begin
                failures++;
                $display("FAIL rst_window_valid bit=%0d got=%0b exp=%0b", i, count_valid, i == 7);
            end
        end
        checks++;
        if (count_out !== 4'd2) begin
            failures++;
            $display("FAIL rst_window_count got=%0d exp=2", count_out);
        end
        step(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gating();
        test_saturation();
        test_overrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
